pixel_scan_ctrl: RTL

Sequences the data memory's read-only pixel port to stream one full image, encrypted (banks 0-3) or decrypted (banks 4-7), to a display or UART sink as a valid/ready byte stream.
- Issues pixel_address in raster order and absorbs memory read latency in a small FIFO.
- Honours sink backpressure without dropping or duplicating pixels.
- Runs alongside the processor, which owns the data memory's address/write port.

---
 rtl/pixel_scan_pkg.sv | 17 +
 rtl/pixel_scan_ctrl_if.sv | 12 +
 rtl/pixel_scan_ctrl_fifo.sv | 54 +++++
 rtl/pixel_scan_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/pixel_scan_pkg.sv
// Shared types and constants for the pixel scan controller.
package pixel_scan_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  localparam int unsigned BANK_BITS = 16;
  localparam int unsigned ENC_BANK  = 0;
  localparam int unsigned DEC_BANK  = 4;

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eol;
    logic       eof;
  } pixel_tag_t;

endpackage

// File: rtl/pixel_scan_ctrl_if.sv
// Valid/ready pixel stream with frame/line tags, from scan controller to sink.
interface pixel_scan_ctrl_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_sof;
  logic       out_eol;
  logic       out_eof;

  modport master (output out_data, out_valid, out_sof, out_eol, out_eof, input out_ready);
  modport slave  (input out_data, out_valid, out_sof, out_eol, out_eof, output out_ready);
endinterface

// File: rtl/pixel_scan_ctrl_fifo.sv
// Synchronous FIFO of tagged pixels with occupancy count and async reset.
module pixel_fifo
  import pixel_scan_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  pixel_tag_t    wr_data,
  input  logic          rd_en,
  output pixel_tag_t    rd_data,
  output logic          empty,
  output logic [CW-1:0] count
);

  pixel_tag_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_rd;

  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];
  assign empty   = (count == '0);

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= bump(wr_ptr);
      if (do_rd) rd_ptr <= bump(rd_ptr);
      unique case ({wr_en, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  overflow: assert property (@(posedge clk) disable iff (rst)
    !(wr_en && !do_rd && count == CW'(DEPTH)));

endmodule

// File: rtl/pixel_scan_ctrl.sv
// Raster-order pixel reader: issues memory addresses, absorbs read latency
// in a small FIFO and streams tagged pixels to a valid/ready sink.
module pixel_scan_ctrl
  import pixel_scan_pkg::*;
#(
  parameter int unsigned IMG_W      = 512,
  parameter int unsigned IMG_H      = 512,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              img_sel,
  output logic [31:0]       pixel_address,
  input  logic [7:0]        pixel,
  pixel_scan_ctrl_if.master stream,
  output logic              busy,
  output logic              done
);

  localparam int unsigned NPIX = IMG_W * IMG_H;
  localparam int unsigned CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned FCW  = $clog2(FIFO_DEPTH + 1);

  state_t              state, state_d;
  logic                sel_q;
  logic [17:0]         idx;
  logic [CW-1:0]       col;
  logic [RW-1:0]       row;
  logic [RD_LAT-1:0]   vld;
  logic [3*RD_LAT-1:0] tag_sr;
  logic [2:0]          issue_tag;
  logic [FCW-1:0]      fifo_count;
  logic                fifo_empty, issue, last, pop;
  int unsigned         inflight;
  pixel_tag_t          head, wr_tag;

  assign last      = (idx == 18'(NPIX - 1));
  assign pop       = !fifo_empty && stream.out_ready;
  assign inflight  = $countones(vld);
  // Credit check counts reads still in the memory pipe so the FIFO cannot overflow.
  assign issue     = (state == SCAN) &&
                     ((32'(fifo_count) + inflight) < (FIFO_DEPTH + 32'(pop)));
  assign issue_tag = {idx == '0, col == CW'(IMG_W - 1),
                      (col == CW'(IMG_W - 1)) && (row == RW'(IMG_H - 1))};

  assign pixel_address = ((sel_q ? DEC_BANK : ENC_BANK) << BANK_BITS) | 32'(idx);
  assign busy          = (state != IDLE);
  assign done          = (state == DRAIN) && pop && head.eof;

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (issue && last) state_d = DRAIN;
      DRAIN:   if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // idx holds on the last issue so the address stays put through DRAIN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q <= 1'b0;
      idx   <= '0;
      col   <= '0;
      row   <= '0;
    end else if (state == IDLE && start) begin
      sel_q <= img_sel;
      idx   <= '0;
      col   <= '0;
      row   <= '0;
    end else if (issue && !last) begin
      idx <= idx + 1'b1;
      if (col == CW'(IMG_W - 1)) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld    <= '0;
      tag_sr <= '0;
    end else begin
      vld    <= RD_LAT'({vld, issue});
      tag_sr <= (3 * RD_LAT)'({tag_sr, issue_tag});
    end
  end

  assign wr_tag = '{data: pixel,
                    sof:  tag_sr[3*RD_LAT-1],
                    eol:  tag_sr[3*RD_LAT-2],
                    eof:  tag_sr[3*RD_LAT-3]};

  pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .wr_en   (vld[RD_LAT-1]),
    .wr_data (wr_tag),
    .rd_en   (stream.out_ready),
    .rd_data (head),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign stream.out_valid = !fifo_empty;
  assign stream.out_data  = fifo_empty ? '0 : head.data;
  assign stream.out_sof   = !fifo_empty && head.sof;
  assign stream.out_eol   = !fifo_empty && head.eol;
  assign stream.out_eof   = !fifo_empty && head.eof;

endmodule
